// File: rtl/fp_pipe_pkg.sv
// Shared widths and helpers for the floating-point datapath pipeline buffers.
package fp_pipe_pkg;

    localparam int FP_MANT_W = 24;
    localparam int FP_EXP_W  = 8;
    localparam int FP_CH     = 4;

    typedef logic [FP_EXP_W-1:0] fp_exp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fp_pipe_stage.sv
// One elastic register stage: valid bit plus data word.
// Latency: 1 cycle. Backpressure: loads only while empty or while the next stage drains it.
// Ready out is combinational from next-stage ready so bubbles collapse.
module fp_pipe_stage #(
    parameter int DW = 96
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush_i,
    input  logic          vld_i,
    input  logic [DW-1:0] dat_i,
    input  logic          nxt_rdy_i,
    output logic          rdy_o,
    output logic          vld_o,
    output logic [DW-1:0] dat_o
);

    logic          vld_q;
    logic          vld_d;
    logic [DW-1:0] dat_q;
    logic [DW-1:0] dat_d;

    assign rdy_o = !vld_q || nxt_rdy_i;

    // Data only moves on a real transfer; an empty stage keeps stale data.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush_i) begin
            vld_d = 1'b0;
        end else if (rdy_o) begin
            vld_d = vld_i;
            if (vld_i) begin
                dat_d = dat_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/fp_pipe_buf.sv
// Elastic DEPTH-stage buffer carrying CH independent W-bit channels, with flush and occupancy.
// Latency: DEPTH cycles from input sampling to output when unstalled.
// Backpressure: combinational ready chain from out_ready; full pipe passes through when out_ready=1.
module fp_pipe_buf
    import fp_pipe_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CH    = FP_CH,
    parameter int W     = FP_MANT_W,
    localparam int OCC_W = clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH*W-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH*W-1:0]   out_data,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int DW = CH * W;

    logic             in_hs;
    logic             out_hs;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Per-stage wires live inside each generate iteration so the ready
    // chain is a set of distinct nets rather than one self-referencing vector.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic          ld_vld;
        logic [DW-1:0] ld_dat;
        logic          nxt_rdy;
        logic          rdy;
        logic          vld;
        logic [DW-1:0] dat;

        if (i == DEPTH - 1) begin : g_tail
            assign nxt_rdy = out_ready;
        end else begin : g_mid
            assign nxt_rdy = g_stage[i+1].rdy;
        end

        if (i == 0) begin : g_head
            assign ld_vld = in_hs;
            assign ld_dat = in_data;
        end else begin : g_body
            assign ld_vld = g_stage[i-1].vld;
            assign ld_dat = g_stage[i-1].dat;
        end

        fp_pipe_stage #(
            .DW(DW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush_i   (flush),
            .vld_i     (ld_vld),
            .dat_i     (ld_dat),
            .nxt_rdy_i (nxt_rdy),
            .rdy_o     (rdy),
            .vld_o     (vld),
            .dat_o     (dat)
        );
    end

    assign in_ready  = g_stage[0].rdy && !flush;
    assign out_valid = g_stage[DEPTH-1].vld;
    assign out_data  = g_stage[DEPTH-1].dat;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (in_hs && !out_hs) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (!in_hs && out_hs) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

    a_occ_max: assert property (@(posedge clk) disable iff (!rst_n) occ_q <= OCC_W'(DEPTH));
    a_occ_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        (out_hs && !in_hs) |-> (occ_q != '0));

endmodule

// File: tb/tb_fp_pipe_buf.sv
// Directed-vector bench for fp_pipe_buf plus random scoreboard runs at DEPTH=1 and DEPTH=4.
module tb_fp_pipe_buf;

    logic clk;
    logic rst_n;

    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [95:0] out_data;
    logic [1:0]  occupancy;

    logic       a_fl, a_iv, a_ir, a_ov, a_or;
    logic [7:0] a_id, a_od;
    logic [0:0] a_occ;
    logic       b_fl, b_iv, b_ir, b_ov, b_or;
    logic [7:0] b_id, b_od;
    logic [2:0] b_occ;

    int checks;
    int errors;

    fp_pipe_buf #(.DEPTH(2), .CH(4), .W(24)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    fp_pipe_buf #(.DEPTH(1), .CH(1), .W(8)) dut_d1 (
        .clk(clk), .rst_n(rst_n), .flush(a_fl),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .occupancy(a_occ)
    );

    fp_pipe_buf #(.DEPTH(4), .CH(1), .W(8)) dut_d4 (
        .clk(clk), .rst_n(rst_n), .flush(b_fl),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .occupancy(b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    typedef struct {
        logic        fl;
        logic        iv;
        logic        ordy;
        logic [19:0] iw;
        logic        e_ir;
        logic        e_ov;
        logic [19:0] e_ow;
        int          e_occ;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mv(input logic fl, input logic iv, input logic ordy, input logic [19:0] iw,
                                input logic e_ir, input logic e_ov, input logic [19:0] e_ow, input int e_occ);
        vec_t v;
        v.fl = fl; v.iv = iv; v.ordy = ordy; v.iw = iw;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_ow = e_ow; v.e_occ = e_occ;
        return v;
    endfunction

    // Channel k carries {k, word} so a channel swap is visible.
    function automatic logic [95:0] mk(input logic [19:0] w);
        logic [95:0] r;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[k*24 +: 24] = {4'(k), w};
        end
        return r;
    endfunction

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    logic [7:0] a_cnt, b_cnt;
    logic       a_acc, b_acc;
    logic       a_hold, b_hold;
    logic [7:0] a_prev, b_prev;
    logic [7:0] a_q[$];
    logic [7:0] b_q[$];

    initial begin
        checks = 0;
        errors = 0;

        // streaming: one word per cycle, first output one edge after the accept edge
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mv(0, 1, 1, 20'(k + 1), 1, (k >= 2), 20'(k - 1), (k == 0) ? 0 : ((k == 1) ? 1 : 2)));
        end
        vecs.push_back(mv(0, 0, 1, 0, 1, 1, 20'h7, 2));
        vecs.push_back(mv(0, 0, 1, 0, 1, 1, 20'h8, 1));
        vecs.push_back(mv(0, 0, 1, 0, 1, 0, 0, 0));
        // backpressure: third word refused for five stalled cycles, then pass-through
        vecs.push_back(mv(0, 1, 0, 20'h11, 1, 0, 0, 0));
        vecs.push_back(mv(0, 1, 0, 20'h12, 1, 0, 0, 1));
        for (int k = 0; k < 5; k++) vecs.push_back(mv(0, 1, 0, 20'h13, 0, 1, 20'h11, 2));
        vecs.push_back(mv(0, 1, 1, 20'h13, 1, 1, 20'h11, 2));
        vecs.push_back(mv(0, 0, 1, 0, 1, 1, 20'h12, 2));
        vecs.push_back(mv(0, 0, 1, 0, 1, 1, 20'h13, 1));
        vecs.push_back(mv(0, 0, 1, 0, 1, 0, 0, 0));
        // bubble collapse under stall
        vecs.push_back(mv(0, 1, 0, 20'h21, 1, 0, 0, 0));
        vecs.push_back(mv(0, 0, 0, 0, 1, 0, 0, 1));
        vecs.push_back(mv(0, 1, 0, 20'h22, 1, 1, 20'h21, 1));
        vecs.push_back(mv(0, 0, 0, 0, 0, 1, 20'h21, 2));
        vecs.push_back(mv(0, 0, 1, 0, 1, 1, 20'h21, 2));
        vecs.push_back(mv(0, 0, 1, 0, 1, 1, 20'h22, 1));
        vecs.push_back(mv(0, 0, 1, 0, 1, 0, 0, 0));
        // flush while full and stalled
        vecs.push_back(mv(0, 1, 0, 20'h31, 1, 0, 0, 0));
        vecs.push_back(mv(0, 1, 0, 20'h32, 1, 0, 0, 1));
        vecs.push_back(mv(1, 1, 0, 20'h33, 0, 1, 20'h31, 2));
        vecs.push_back(mv(0, 0, 1, 0, 1, 0, 0, 0));
        // flush coinciding with an output handshake; flushed input never appears
        vecs.push_back(mv(0, 1, 0, 20'h41, 1, 0, 0, 0));
        vecs.push_back(mv(0, 1, 0, 20'h42, 1, 0, 0, 1));
        vecs.push_back(mv(1, 1, 1, 20'h43, 0, 1, 20'h41, 2));
        vecs.push_back(mv(0, 0, 1, 0, 1, 0, 0, 0));
        vecs.push_back(mv(0, 1, 1, 20'h44, 1, 0, 0, 0));
        vecs.push_back(mv(0, 0, 1, 0, 1, 0, 0, 1));
        vecs.push_back(mv(0, 0, 1, 0, 1, 1, 20'h44, 1));
        vecs.push_back(mv(0, 0, 1, 0, 1, 0, 0, 0));

        rst_n = 1'b0;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        a_fl = 1'b0; a_iv = 1'b0; a_or = 1'b0; a_id = '0;
        b_fl = 1'b0; b_iv = 1'b0; b_or = 1'b0; b_id = '0;

        #1;
        check("reset.out_valid", 96'(out_valid), 96'(0));
        check("reset.out_data", out_data, 96'(0));
        check("reset.occupancy", 96'(occupancy), 96'(0));

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset.in_ready", 96'(in_ready), 96'(1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            flush = vecs[i].fl;
            in_valid = vecs[i].iv;
            out_ready = vecs[i].ordy;
            in_data = mk(vecs[i].iw);
            #1;
            check($sformatf("vec%0d.in_ready", i), 96'(in_ready), 96'(vecs[i].e_ir));
            check($sformatf("vec%0d.out_valid", i), 96'(out_valid), 96'(vecs[i].e_ov));
            check($sformatf("vec%0d.occupancy", i), 96'(occupancy), 96'(vecs[i].e_occ));
            if (vecs[i].e_ov) check($sformatf("vec%0d.out_data", i), out_data, mk(vecs[i].e_ow));
        end

        // reset mid-stream with one entry sitting in the output stage
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = mk(20'h51);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst.pre_valid", 96'(out_valid), 96'(1));
        check("midrst.pre_occ", 96'(occupancy), 96'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", 96'(out_valid), 96'(0));
        check("midrst.out_data", out_data, 96'(0));
        check("midrst.occupancy", 96'(occupancy), 96'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst.in_ready", 96'(in_ready), 96'(1));
        in_valid = 1'b1; out_ready = 1'b1; in_data = mk(20'h61);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        check("midrst.resume_valid", 96'(out_valid), 96'(1));
        check("midrst.resume_data", out_data, mk(20'h61));
        check("midrst.resume_occ", 96'(occupancy), 96'(1));
        @(negedge clk);
        #1;
        check("midrst.drained", 96'(occupancy), 96'(0));

        // random valid/ready at DEPTH=1 and DEPTH=4 against an in-order scoreboard
        a_cnt = '0; b_cnt = '0; a_acc = 1'b0; b_acc = 1'b0;
        a_hold = 1'b0; b_hold = 1'b0; a_prev = '0; b_prev = '0;
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            if (a_acc) a_cnt = a_cnt + 8'd1;
            if (b_acc) b_cnt = b_cnt + 8'd1;
            a_iv = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            b_iv = (c < 400) ? 1'($urandom_range(0, 1)) : 1'b0;
            a_or = (c < 400) ? ($urandom_range(0, 3) != 0) : 1'b1;
            b_or = (c < 400) ? ($urandom_range(0, 2) == 0) : 1'b1;
            a_id = a_cnt;
            b_id = b_cnt;
            #1;
            check("d1.occupancy", 96'(a_occ), 96'(a_q.size()));
            check("d4.occupancy", 96'(b_occ), 96'(b_q.size()));
            check("d1.occ_le_depth", 96'(a_occ <= 1), 96'(1));
            check("d4.occ_le_depth", 96'(b_occ <= 4), 96'(1));
            if (a_hold) begin
                check("d1.hold_valid", 96'(a_ov), 96'(1));
                check("d1.hold_data", 96'(a_od), 96'(a_prev));
            end
            if (b_hold) begin
                check("d4.hold_valid", 96'(b_ov), 96'(1));
                check("d4.hold_data", 96'(b_od), 96'(b_prev));
            end
            if (a_ov && a_or) begin
                if (a_q.size() == 0) check("d1.spurious_out", 96'(a_ov), 96'(0));
                else check("d1.order", 96'(a_od), 96'(a_q.pop_front()));
            end
            if (b_ov && b_or) begin
                if (b_q.size() == 0) check("d4.spurious_out", 96'(b_ov), 96'(0));
                else check("d4.order", 96'(b_od), 96'(b_q.pop_front()));
            end
            a_acc = a_iv && a_ir;
            b_acc = b_iv && b_ir;
            if (a_acc) a_q.push_back(a_id);
            if (b_acc) b_q.push_back(b_id);
            a_hold = a_ov && !a_or;
            b_hold = b_ov && !b_or;
            a_prev = a_od;
            b_prev = b_od;
        end
        check("d1.final_valid", 96'(a_ov), 96'(0));
        check("d4.final_valid", 96'(b_ov), 96'(0));
        check("d1.final_occ", 96'(a_occ), 96'(0));
        check("d4.final_occ", 96'(b_occ), 96'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_pipe_buf.md
# fp_pipe_buf

Parametrised elastic pipeline buffer for the floating-point datapath. It carries CH independent W-bit channels through DEPTH register stages. A valid/ready handshake lets the multiplier and adder stages stall under backpressure without losing or duplicating data. A synchronous flush and an occupancy counter support pipeline drain and debug. It replaces the fixed 4×24-bit, always-enabled stage registers between mantissa-multiply stages.

## Interface
- DEPTH, 2: number of register stages, ≥1
- CH, 4: number of channels, ≥1
- W, 24: bits per channel, ≥1
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all stages
- in_valid  input  1  upstream has data on in_data
- in_ready  output  1  buffer accepts in_data this cycle
- in_data  input  CH*W  channel k occupies bits [k*W +: W]
- out_valid  output  1  out_data holds a valid entry
- out_ready  input  1  downstream consumes this cycle
- out_data  output  CH*W  same packing as in_data
- occupancy  output  OCC_W = clog2(DEPTH+1)  number of valid entries held

## Operation
- Each stage i (0 = input side, DEPTH-1 = output) holds a valid bit v[i] and a CH*W data word d[i].
- Stage ready: r[DEPTH-1] = !v[DEPTH-1] || out_ready; r[i] = !v[i] || r[i+1]. The ready chain is combinational, so bubbles collapse.
- in_ready = r[0] && !flush.
- Stage i loads when r[i] is high. Stage 0 loads in_data and sets v[0] = in_valid && in_ready. Stage i>0 loads d[i-1] and takes v[i] = v[i-1].
- Data registers load only on a valid transfer. Invalid stages keep their old data, which is don't-care.
- out_valid = v[DEPTH-1]; out_data = d[DEPTH-1].
- Occupancy counter:
  - +1 on input handshake (in_valid && in_ready).
  - -1 on output handshake (out_valid && out_ready).
  - Unchanged when both happen in the same cycle.
  - Never exceeds DEPTH and never underflows. An assertion checks this.
- Flush at a clock edge:
  - All v[i] are cleared and occupancy goes to 0.
  - in_ready is held at 0, so no input is accepted that cycle.
  - An output handshake coinciding with flush still completes downstream, but the entry is not re-presented.
- Channels are fully independent bit-slices. No arithmetic is performed on data.

## Timing
- Reset, asynchronous on rst_n low:
  - All v[i] = 0, all d[i] = 0.
  - out_valid = 0, out_data = 0, occupancy = 0.
  - in_ready = 1 as soon as reset is released (when flush = 0).
- Reset asserted mid-operation discards all entries immediately, without waiting for a clock.
- Latency: an entry accepted at edge n appears on out_valid/out_data after edge n+DEPTH-1, i.e. DEPTH cycles from in_data sampling to out_data available, when no stall occurs.
- Throughput: one entry per cycle while out_ready = 1.
- Full condition: when all DEPTH stages are valid and out_ready = 0, in_ready = 0. When full and out_ready = 1, in_ready = 1 in the same cycle (pass-through).
- Empty condition: out_valid = 0 and occupancy = 0. A bubble inside the pipe is overwritten when a downstream stall leaves it free.
- Combinational paths: out_ready → in_ready (DEPTH-deep chain) and flush → in_ready. There is no path from in_valid to out_valid.
- Holding rule: out_data and out_valid must stay stable while out_valid = 1 and out_ready = 0.

## Structure
- Package fp_pipe_pkg:
  - Function clog2, used for OCC_W.
  - Default widths: FP_MANT_W = 24, FP_EXP_W = 8, FP_CH = 4.
- Sub-module fp_pipe_stage holds one stage (v, d, load logic, ready out). fp_pipe_buf instantiates it DEPTH times in a generate loop.
- The occupancy counter and flush gating live in the top module.

## Test plan
- Streaming, DEPTH=2, CH=4, W=24: drive in_valid=1 continuously with out_ready=1 and words 0x000001..0x000008 per channel. Require:
  - first out_valid 2 cycles after the first accept,
  - 8 outputs in order, one per cycle,
  - occupancy steady at 2.
- Backpressure: fill with 3 entries, out_ready=0 for 5 cycles. Require:
  - in_ready=0 after 2 accepts,
  - out_data held at the first word,
  - occupancy=2.
  Then raise out_ready and require in-order drain with no loss.
- Bubble collapse: send A, idle 1 cycle, send B, with out_ready=0. Require occupancy=2 and in_ready=0. Release out_ready and require A then B on consecutive cycles.
- Flush while full: out_ready=0, occupancy=2, assert flush 1 cycle with in_valid=1. Require:
  - next cycle out_valid=0, occupancy=0,
  - the input word during flush is never output.
- Reset mid-stream: drop rst_n between edges while occupancy=1. Require out_valid=0, out_data=0 and occupancy=0 immediately. After release, require in_ready=1 and normal operation.
- Parameter sweep: run DEPTH=1,4 with CH=1, W=8 using random valid/ready. A scoreboard requires an exact in-order match and occupancy ≤ DEPTH.
